// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin burst scheduler sharing one downstream FIFO among N_PORTS upstream FIFOs
// Optional statistics (xfer_cnt, stall_cnt) are built only when ARB_STATS_EN is defined.
module fifo_rr_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int BITS      = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PORTS-1:0]      pndng,
  input  logic [N_PORTS*BITS-1:0] din,
  output logic [N_PORTS-1:0]      pop,
  input  logic                    full,
  output logic                    push,
  output logic [BITS-1:0]         dout,
  output logic [N_PORTS-1:0]      grant,
  output logic                    busy
`ifdef ARB_STATS_EN
  ,
  output logic [N_PORTS*16-1:0]   xfer_cnt,
  output logic [15:0]             stall_cnt
`endif
);
  localparam int PW  = $clog2(N_PORTS);
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_n;
  logic [N_PORTS-1:0] grant_n;
  logic [PW-1:0]      owner, owner_n;
  logic [PW-1:0]      rr_ptr, rr_ptr_n;
  logic [PW-1:0]      sel_idx, cand;
  logic [PW:0]        sum;
  logic               sel_found;
  logic [CW-1:0]      burst_cnt, burst_cnt_n;
  logic [BITS-1:0]    din_w [N_PORTS];
  logic               xfer, last_word, release_g;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_din
    assign din_w[i] = din[i*BITS +: BITS];
  end

  // First pending port at or after rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      sum = {1'b0, rr_ptr} + PW1'(k);
      if (sum >= PW1'(N_PORTS)) sum = sum - PW1'(N_PORTS);
      cand = sum[PW-1:0];
      if (!sel_found && pndng[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign xfer      = (state == BURST) && pndng[owner] && !full && !rst;
  assign last_word = (burst_cnt == CW'(MAX_BURST - 1));
  assign release_g = (state == BURST) && ((xfer && last_word) || !pndng[owner]);
  assign pop       = xfer ? grant : '0;
  assign push      = xfer;
  assign dout      = (state == BURST) ? din_w[owner] : '0;
  assign busy      = (state == BURST);

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    owner_n     = owner;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_n          = BURST;
          grant_n          = '0;
          grant_n[sel_idx] = 1'b1;
          owner_n          = sel_idx;
          burst_cnt_n      = '0;
        end
      end
      BURST: begin
        if (release_g) begin
          state_n     = IDLE;
          grant_n     = '0;
          rr_ptr_n    = (owner == PW'(N_PORTS - 1)) ? '0 : owner + PW'(1);
          burst_cnt_n = '0;
        end else if (xfer) begin
          burst_cnt_n = burst_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
    end
  end

`ifdef ARB_STATS_EN
  logic stall;
  assign stall = (state == BURST) && pndng[owner] && full;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_xcnt
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (pop[i] && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign xfer_cnt[i*16 +: 16] = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - scoreboard bench for fifo_rr_arbiter (upstream FIFO model, downstream monitor)
module tb_fifo_rr_arbiter;
  localparam int NP = 4;
  localparam int BW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    pndng = '0;
  logic [NP*BW-1:0] din = '0;
  logic [NP-1:0]    pop;
  logic             full = 1'b0;
  logic             push;
  logic [BW-1:0]    dout;
  logic [NP-1:0]    grant;
  logic             busy;
`ifdef ARB_STATS_EN
  logic [NP*16-1:0] xfer_cnt;
  logic [15:0]      stall_cnt;
`endif

  fifo_rr_arbiter #(.N_PORTS(NP), .BITS(BW), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst), .pndng(pndng), .din(din), .pop(pop), .full(full),
    .push(push), .dout(dout), .grant(grant), .busy(busy)
`ifdef ARB_STATS_EN
    , .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [NP-1:0] grant;
  } exp_t;

  exp_t          expq[$];
  exp_t          e;
  logic [BW-1:0] upq[NP][$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic          sb_on = 1'b0;
  logic [NP-1:0] pop_s, grant_s;
  logic          push_s;

  function automatic logic [BW-1:0] mkw(int t, int p, int s);
    return BW'((t << 24) | (p << 20) | s);
  endfunction

  task automatic chk(string nm, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      pndng[i] = (upq[i].size() != 0);
      din[i*BW +: BW] = (upq[i].size() != 0) ? upq[i][0] : '0;
    end
  endtask

  task automatic load(int p, int n, int t);
    for (int s = 0; s < n; s++) upq[p].push_back(mkw(t, p, s));
    refresh();
  endtask

  task automatic exp_add(int p, int first, int last, int t);
    exp_t x;
    for (int s = first; s <= last; s++) begin
      x.data  = mkw(t, p, s);
      x.grant = NP'(1) << p;
      expq.push_back(x);
    end
  endtask

  // One clock: sample away from the edge, then the upstream FIFOs consume what was popped.
  task automatic tick();
    @(negedge clk);
    pop_s   = pop;
    push_s  = push;
    grant_s = grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++)
      if (pop_s[i] && upq[i].size() != 0) void'(upq[i].pop_front());
    refresh();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NP; i++) if (upq[i].size() != 0) return 1'b0;
    return (expq.size() == 0) && (grant == '0);
  endfunction

  task automatic drain(string nm, int maxc);
    int c;
    c = 0;
    while (c < maxc && !all_idle()) begin
      tick();
      c++;
    end
    chk(nm, longint'(all_idle()), 1);
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      n_checks++;
      if (((pop & (pop - NP'(1))) != '0) || (push !== (|pop)) ||
          ((pop & ~pndng) != '0) || (push && full)) begin
        n_fail++;
        $display("FAIL invariant: pop=%b push=%b pndng=%b full=%b", pop, push, pndng, full);
      end
      if (push === 1'b1) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_push: dout=%h grant=%b, nothing expected", dout, grant);
        end else begin
          e = expq.pop_front();
          if (dout !== e.data || grant !== e.grant) begin
            n_fail++;
            $display("FAIL sb_word: got dout=%h grant=%b expected dout=%h grant=%b",
                     dout, grant, e.data, e.grant);
          end
        end
      end
    end
  end

  initial begin
    int cnt, c, first, last;

    // Reset with every port pending
    for (int p = 0; p < NP; p++) load(p, 1, 1);
    tick();
    sb_on = 1'b1;
    tick();
    chk("rst_pop", pop_s, 0);
    chk("rst_push", push_s, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    for (int p = 0; p < NP; p++) exp_add(p, 0, 0, 1);
    rst = 1'b0;
    tick();
    chk("first_grant", grant, 4'b0001);
    drain("t1_drain", 100);

    // Ports 0 and 2, 20 words each: bursts 8,8,8,8,4,4 alternating
    load(0, 20, 2);
    load(2, 20, 2);
    for (int r = 0; r < 3; r++) begin
      exp_add(0, r*8, (r < 2) ? r*8+7 : r*8+3, 2);
      exp_add(2, r*8, (r < 2) ? r*8+7 : r*8+3, 2);
    end
    drain("t2_drain", 400);

    // Port 1 alone, 3 words back to back
    load(1, 3, 3);
    exp_add(1, 0, 2, 3);
    cnt = 0; first = -1; last = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (push_s) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("t3_push_count", cnt, 3);
    chk("t3_consecutive", last - first, 2);
    drain("t3_drain", 50);

    // rr_ptr now 2: port 2 wins over port 1, then port 1 still served
    load(1, 1, 4);
    load(2, 1, 4);
    exp_add(2, 0, 0, 4);
    exp_add(1, 0, 0, 4);
    tick();
    chk("t3_rr_grant", grant, 4'b0100);
    drain("t3b_drain", 50);

    // Full stall for 5 cycles mid-burst
    load(0, 10, 5);
    exp_add(0, 0, 9, 5);
    cnt = 0; c = 0;
    while (cnt < 2 && c < 10) begin
      tick();
      if (push_s) cnt++;
      c++;
    end
    chk("t4_prestall", cnt, 2);
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_stall_push", push_s, 0);
      chk("t4_stall_pop", pop_s, 0);
      chk("t4_stall_grant", grant_s, 4'b0001);
    end
    full = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (grant_s == '0) break;
      if (push_s) cnt++;
    end
    chk("t4_burst_len", cnt, 8);
    drain("t4_drain", 60);
`ifdef ARB_STATS_EN
    chk("stats_stall", stall_cnt, 5);
    chk("stats_p0", xfer_cnt[15:0], 31);
    chk("stats_p1", xfer_cnt[31:16], 5);
    chk("stats_p2", xfer_cnt[47:32], 22);
    chk("stats_p3", xfer_cnt[63:48], 1);
`endif

    // Reset on the third word of a burst
    load(3, 5, 6);
    exp_add(3, 0, 4, 6);
    cnt = 0; c = 0;
    while (cnt < 2 && c < 10) begin
      tick();
      if (push_s) cnt++;
      c++;
    end
    chk("t5_prerst", cnt, 2);
    rst = 1'b1;
    tick();
    chk("t5_rst_push", push_s, 0);
    chk("t5_rst_pop", pop_s, 0);
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_upstream_left", upq[3].size(), 3);
    rst = 1'b0;
    drain("t5_drain", 50);

`ifdef ARB_STATS_EN
    // Saturation of the per-port word counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_clr_p3", xfer_cnt[63:48], 0);
    chk("t6_clr_stall", stall_cnt, 0);
    load(3, 70000, 7);
    exp_add(3, 0, 69999, 7);
    drain("t6_drain", 80000);
    chk("t6_sat_p3", xfer_cnt[63:48], 16'hFFFF);
    chk("t6_p0", xfer_cnt[15:0], 0);
    chk("t6_p1", xfer_cnt[31:16], 0);
    chk("t6_p2", xfer_cnt[47:32], 0);
`endif

    chk("sb_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Round-robin scheduler that shares one downstream FIFO among N_PORTS upstream FIFOs in the router datapath. Watches each upstream FIFO's pndng flag, issues pop to one granted FIFO at a time, and forwards that word to the downstream FIFO with push, gated by downstream full. Grants are held for bursts of up to MAX_BURST words to limit header/payload interleaving. By construction it never pops an empty FIFO and never pushes into a full one.

Parameters:
N_PORTS, 4, number of upstream FIFOs (2..16)
BITS, 32, data word width
MAX_BURST, 8, maximum consecutive words forwarded per grant (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
pndng  in  N_PORTS  per-port upstream FIFO non-empty flag
din  in  N_PORTS*BITS  per-port upstream FIFO head data, first-word fall-through; port i at bits [i*BITS +: BITS]
pop  out  N_PORTS  per-port upstream pop strobe, one-hot or zero
full  in  1  downstream FIFO full flag
push  out  1  downstream push strobe
dout  out  BITS  data to downstream FIFO
grant  out  N_PORTS  registered one-hot current owner; zero when IDLE
busy  out  1  high in BURST state

Behaviour:
- Reset (rst high at posedge): state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, busy=0. pop=0 and push=0 while rst high, regardless of other inputs.
- State IDLE: if any pndng, choose the first set port searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., N_PORTS-1, 0, ...). Next cycle: grant=that port, state=BURST, burst_cnt=0. No pop/push in IDLE cycles. This gives 1 cycle arbitration latency.
- State BURST, owner g:
  - xfer = pndng[g] && !full.
  - pop[g] = push = xfer, combinational, same cycle.
  - dout = din[g] always while in BURST. dout=0 in IDLE.
  - On xfer, burst_cnt increments.
  - Release when (xfer && burst_cnt==MAX_BURST-1) or !pndng[g]:
    - state to IDLE, grant=0, rr_ptr=(g+1) mod N_PORTS, burst_cnt=0.
  - If full stalls the burst, hold: no release, count unchanged, grant unchanged.
- A port is never starved. Worst-case wait is (N_PORTS-1)*(MAX_BURST+1)+1 cycles, excluding full stalls.
- Invariants: pop is one-hot or zero; push==|pop; pop[i] implies pndng[i]; push implies !full.
- burst_cnt width is $clog2(MAX_BURST)+1. rr_ptr width is $clog2(N_PORTS).
- A single-requester case still passes through IDLE between bursts: a 1-cycle bubble every MAX_BURST words.
- Reset mid-burst: transfer aborted immediately. No pop/push in the reset cycle. Upstream data is not lost.

Optional Feature:
ARB_STATS_EN. When defined:
- Adds output port xfer_cnt (N_PORTS*16): per-port saturating count of words forwarded. Increments on each pop[i], saturates at 16'hFFFF, cleared by rst.
- Adds output stall_cnt (16): count of BURST cycles with pndng[g] && full, saturating.
When undefined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
1. Reset with all pndng=1 -> pop=0, push=0, grant=0 during rst. First grant after release = 4'b0001.
2. N_PORTS=4, MAX_BURST=8, ports 0 and 2 each holding 20 words, full=0 -> grant sequence 0,2,0,2,0,2. Bursts of 8,8,8,8,4,4 words. One idle cycle between bursts. dout order matches per-port FIFO order.
3. Port 1 alone, 3 words -> pushes on 3 consecutive cycles, then release on pndng drop. rr_ptr=2. Next request from port 1 is still granted.
4. Mid-burst, full=1 for 5 cycles -> push=0 and pop=0 for those 5 cycles. grant and burst_cnt held. Transfer resumes on full=0 with no lost or duplicated word.
5. rst asserted on the 3rd word of a burst -> next cycle state IDLE, grant=0. Upstream count has decreased by exactly 2.
6. ARB_STATS_EN: 70000 words from port 3 -> xfer_cnt[3]=16'hFFFF (saturated). Other port counts are 0.
